// File: rtl/subband_out_serializer_if.sv
// Valid/ready beat bus carrying one quantised subband sample per transfer.
interface subband_out_serializer_if #(
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned BAND_W = 4
);
  logic              m_valid;
  logic              m_ready;
  logic [OUT_W-1:0]  m_data;
  logic [BAND_W-1:0] m_band;
  logic              m_last;
  logic              m_sat;

  modport master (output m_valid, m_data, m_band, m_last, m_sat, input m_ready);
  modport slave  (input m_valid, m_data, m_band, m_last, m_sat, output m_ready);
endinterface

// File: rtl/subband_out_serializer.sv
// Snapshots all filterbank band outputs on a frame strobe and streams them one band per beat,
// rounded half-up and saturated to OUT_W bits.
module subband_out_serializer #(
  parameter int unsigned N_BANDS  = 16,
  parameter int unsigned IN_W     = 35,
  parameter int unsigned IN_FRAC  = 32,
  parameter int unsigned OUT_W    = 16,
  parameter int unsigned OUT_FRAC = 14
) (
  input  logic                      clk_en,
  input  logic                      reset,
  input  logic                      capture,
  input  logic [N_BANDS*IN_W-1:0]   band_in,
  input  logic                      overrun_clr,
  output logic                      overrun,
  subband_out_serializer_if.master  m
);

  localparam int unsigned SHIFT  = IN_FRAC - OUT_FRAC;
  localparam int unsigned BAND_W = $clog2(N_BANDS);
  localparam int unsigned Q_W    = IN_W + 1 - SHIFT;

  localparam logic signed [IN_W:0]  RND   = {{(IN_W+1-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  localparam logic signed [Q_W-1:0] Q_MAX = Q_W'((2**(OUT_W-1)) - 1);
  localparam logic signed [Q_W-1:0] Q_MIN = Q_W'(-(2**(OUT_W-1)));
  localparam logic [BAND_W-1:0]     LAST  = BAND_W'(N_BANDS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state;
  logic [IN_W-1:0] shadow [N_BANDS];

  // Returns {sat, data}: round half up, then clip to the signed OUT_W range.
  function automatic logic [OUT_W:0] quant(input logic [IN_W-1:0] x);
    logic signed [IN_W:0]  t;
    logic signed [Q_W-1:0] q;
    logic [OUT_W:0]        r;
    t = $signed({x[IN_W-1], x}) + RND;
    q = Q_W'(t >>> SHIFT);
    if (q > Q_MAX)      r = {1'b1, OUT_W'(Q_MAX)};
    else if (q < Q_MIN) r = {1'b1, OUT_W'(Q_MIN)};
    else                r = {1'b0, OUT_W'(q)};
    return r;
  endfunction

  logic              hs;
  logic              last_beat;
  logic              take;
  logic [BAND_W-1:0] nxt_band;
  logic [OUT_W:0]    q_first;
  logic [OUT_W:0]    q_next;

  // A capture is accepted when idle, or when it coincides with the final handshake of a frame.
  always_comb begin
    hs        = m.m_valid & m.m_ready;
    last_beat = (m.m_band == LAST);
    take      = capture & ((state == IDLE) | (hs & last_beat));
    nxt_band  = m.m_band + BAND_W'(1);
    q_first   = quant(band_in[IN_W-1:0]);
    q_next    = quant(shadow[nxt_band]);
  end

  always_ff @(posedge clk_en) begin
    if (reset) begin
      state     <= IDLE;
      m.m_valid <= 1'b0;
      m.m_data  <= '0;
      m.m_band  <= '0;
      m.m_last  <= 1'b0;
      m.m_sat   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (capture && !take)  overrun <= 1'b1;
      else if (overrun_clr)  overrun <= 1'b0;

      if (take) begin
        for (int unsigned k = 0; k < N_BANDS; k++) shadow[k] <= band_in[k*IN_W +: IN_W];
        state     <= SEND;
        m.m_valid <= 1'b1;
        m.m_data  <= q_first[OUT_W-1:0];
        m.m_sat   <= q_first[OUT_W];
        m.m_band  <= '0;
        m.m_last  <= (LAST == '0);
      end else if (state == SEND && hs) begin
        if (last_beat) begin
          state     <= IDLE;
          m.m_valid <= 1'b0;
        end else begin
          m.m_data  <= q_next[OUT_W-1:0];
          m.m_sat   <= q_next[OUT_W];
          m.m_band  <= nxt_band;
          m.m_last  <= (nxt_band == LAST);
        end
      end
    end
  end

endmodule

// File: tb/tb_subband_out_serializer.sv
// Scoreboard bench for subband_out_serializer: per-frame expected beats are queued at capture.
module tb_subband_out_serializer;

  localparam int unsigned N     = 16;
  localparam int unsigned IN_W  = 35;
  localparam int unsigned OUT_W = 16;
  localparam int unsigned BW    = 4;

  typedef struct {
    longint data;
    int     band;
    bit     last;
    bit     sat;
  } exp_t;

  logic                clk_en = 1'b0;
  logic                reset;
  logic                capture;
  logic                overrun_clr;
  logic                overrun;
  logic [N*IN_W-1:0]   band_in;
  logic [N*IN_W-1:0]   band_next;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  subband_out_serializer_if #(.OUT_W(OUT_W), .BAND_W(BW)) bus ();

  subband_out_serializer dut (
    .clk_en      (clk_en),
    .reset       (reset),
    .capture     (capture),
    .band_in     (band_in),
    .overrun_clr (overrun_clr),
    .overrun     (overrun),
    .m           (bus.master)
  );

  always #5 clk_en = ~clk_en;

  task automatic check_eq(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic void model(input logic [IN_W-1:0] raw, output longint d, output bit s);
    longint x, q;
    x = longint'($signed(raw));
    q = (x + 64'sd131072) >>> 18;
    s = 1'b0;
    if (q > 32767)       begin d = 32767;  s = 1'b1; end
    else if (q < -32768) begin d = -32768; s = 1'b1; end
    else                 d = q;
  endfunction

  task automatic push_frame(input logic [N*IN_W-1:0] b);
    exp_t   e;
    longint d;
    bit     s;
    for (int k = 0; k < N; k++) begin
      model(b[k*IN_W +: IN_W], d, s);
      e.data = d; e.band = k; e.last = (k == N-1); e.sat = s;
      sb.push_back(e);
    end
  endtask

  // Called at a negedge: drive inputs, score any beat accepted at the coming posedge, advance.
  task automatic cyc(input logic cap, input logic rdy, input logic clr, output bit hs);
    exp_t             e;
    bit               hold;
    logic [OUT_W-1:0] hd;
    logic [BW-1:0]    hb;
    capture = cap; bus.m_ready = rdy; overrun_clr = clr;
    hs   = (bus.m_valid === 1'b1) && rdy && !reset;
    hold = (bus.m_valid === 1'b1) && !rdy && !reset;
    hd = bus.m_data; hb = bus.m_band;
    if (hs) begin
      if (sb.size() == 0) check_eq("unexpected_beat", 1, 0);
      else begin
        e = sb.pop_front();
        check_eq("beat_data", $signed(bus.m_data), e.data);
        check_eq("beat_band", bus.m_band, e.band);
        check_eq("beat_last", bus.m_last, e.last);
        check_eq("beat_sat",  bus.m_sat,  e.sat);
      end
    end
    @(posedge clk_en);
    @(negedge clk_en);
    capture = 1'b0; overrun_clr = 1'b0;
    if (hold) begin
      check_eq("hold_data", bus.m_data, hd);
      check_eq("hold_band", bus.m_band, hb);
    end
  endtask

  task automatic start_frame(input logic [N*IN_W-1:0] b);
    bit hs;
    band_in = b;
    push_frame(b);
    cyc(1'b1, 1'b1, 1'b0, hs);
    check_eq("latency_valid", bus.m_valid, 1);
    check_eq("first_band", bus.m_band, 0);
  endtask

  // Drains the current frame; optionally issues a second capture when beat cap_beat is presented.
  task automatic run(input int cap_beat, input logic clr_with_cap, input bit alt_ready, output int cycles);
    bit hs, rdy, cap, cap_done, acc;
    int fb;
    cycles = 0; fb = 0; cap_done = 0;
    while ((sb.size() > 0 || bus.m_valid === 1'b1) && cycles < 200) begin
      rdy = alt_ready ? (cycles % 2 == 1) : 1'b1;
      cap = (cap_beat >= 0) && (fb == cap_beat) && !cap_done;
      acc = 1'b0;
      if (cap) begin
        cap_done = 1;
        band_in  = band_next;
        acc      = (fb == N-1) && rdy;
        if (acc) push_frame(band_next);
      end
      cyc(cap, rdy, cap & clr_with_cap, hs);
      if (cap) check_eq("overrun_after_capture", overrun, !acc);
      if (hs) fb = (fb + 1) % N;
      cycles++;
    end
    if (cycles >= 200) check_eq("drain_timeout", cycles, 0);
  endtask

  function automatic logic [N*IN_W-1:0] ramp(input int scale, input int offs);
    logic [N*IN_W-1:0] b;
    logic [IN_W-1:0]   v;
    for (int k = 0; k < N; k++) begin
      v = IN_W'(longint'(scale * k + offs) <<< 18);
      b[k*IN_W +: IN_W] = v;
    end
    return b;
  endfunction

  initial begin
    bit                hs;
    int                cycles;
    logic [N*IN_W-1:0] b;

    reset = 1'b1; capture = 1'b0; overrun_clr = 1'b0; bus.m_ready = 1'b0;
    band_in = '0; band_next = '0;
    @(negedge clk_en);
    cyc(1'b1, 1'b0, 1'b0, hs);
    cyc(1'b0, 1'b0, 1'b0, hs);
    check_eq("rst_valid",   bus.m_valid, 0);
    check_eq("rst_data",    bus.m_data,  0);
    check_eq("rst_band",    bus.m_band,  0);
    check_eq("rst_last",    bus.m_last,  0);
    check_eq("rst_sat",     bus.m_sat,   0);
    check_eq("rst_overrun", overrun,     0);
    reset = 1'b0;
    cyc(1'b0, 1'b1, 1'b0, hs);

    // Ramp: band k carries k at the output scale
    start_frame(ramp(1, 0));
    run(-1, 1'b0, 1'b0, cycles);
    check_eq("ramp_cycles", cycles, 16);
    check_eq("ramp_idle_valid", bus.m_valid, 0);

    // Rounding at the half-LSB boundaries
    b = '0;
    b[0*IN_W +: IN_W] = IN_W'(64'sh20000);
    b[1*IN_W +: IN_W] = IN_W'(-64'sh20000);
    b[2*IN_W +: IN_W] = IN_W'(64'sh1FFFF);
    b[3*IN_W +: IN_W] = IN_W'(-64'sh20001);
    start_frame(b);
    run(-1, 1'b0, 1'b0, cycles);

    // Saturation at both rails plus an in-range value
    b = '0;
    b[0*IN_W +: IN_W] = IN_W'((64'sd1 <<< 34) - 1);
    b[1*IN_W +: IN_W] = IN_W'(-(64'sd1 <<< 34));
    b[2*IN_W +: IN_W] = IN_W'(64'sd100 <<< 18);
    start_frame(b);
    run(-1, 1'b0, 1'b0, cycles);

    // Backpressure: ready toggles, outputs must hold while stalled
    start_frame(ramp(-3, 7));
    run(-1, 1'b0, 1'b1, cycles);
    check_eq("bp_cycles", cycles, 32);

    // Overrun: second capture mid-frame is dropped, old frame finishes intact
    band_next = ramp(5, -40);
    start_frame(ramp(2, 1));
    run(5, 1'b0, 1'b0, cycles);
    check_eq("ovr_cycles", cycles, 16);
    cyc(1'b0, 1'b1, 1'b0, hs);
    check_eq("ovr_idle_valid", bus.m_valid, 0);
    check_eq("ovr_sticky", overrun, 1);
    cyc(1'b0, 1'b1, 1'b1, hs);
    check_eq("ovr_clr", overrun, 0);
    start_frame(ramp(1, 3));
    run(3, 1'b1, 1'b0, cycles);
    check_eq("ovr_set_wins_cycles", cycles, 16);
    cyc(1'b0, 1'b1, 1'b1, hs);
    check_eq("ovr_clr2", overrun, 0);

    // Back-to-back: capture on the final handshake starts the next frame with no gap
    band_next = ramp(-7, 2);
    start_frame(ramp(4, -30));
    run(N-1, 1'b0, 1'b0, cycles);
    check_eq("b2b_cycles", cycles, 32);
    check_eq("b2b_overrun", overrun, 0);

    // Reset mid-frame discards the partial frame
    start_frame(ramp(1, 10));
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 1'b0, hs);
    reset = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, hs);
    reset = 1'b0;
    check_eq("midrst_valid", bus.m_valid, 0);
    check_eq("midrst_band",  bus.m_band,  0);
    check_eq("midrst_data",  bus.m_data,  0);
    sb.delete();
    cyc(1'b0, 1'b1, 1'b0, hs);
    check_eq("midrst_still_idle", bus.m_valid, 0);
    start_frame(ramp(-2, 50));
    run(-1, 1'b0, 1'b0, cycles);
    check_eq("restart_cycles", cycles, 16);
    check_eq("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
